gate_gen: RTL and testbench
===========================

Name: gate_gen

Overview:
- Generates the gate ("door") window that the frequency/pulse-width counter measures: a programmable high pulse followed by a programmable low gap.
- Runs single-shot or continuous.
- Sits beside the counter in the SSD control test path; door_out drives the counter's door input directly.
- Measured count is high_len in clk cycles, so the pair forms a closed self-check loop.

Parameters:
- CNT_W, 32, width of length registers and internal down-counter.
- LOW_MIN, 2, minimum low-gap cycles enforced between gates; matches the counter's two-cycle reset/capture need.

Ports:
- clk  input  1  system clock.
- nRST  input  1  asynchronous reset, active-low.
- start  input  1  one-cycle request to begin gating; sampled only in IDLE.
- stop  input  1  abort request; honoured in any state.
- cont  input  1  1 = repeat gates until stop; 0 = single gate. Latched on accepted start.
- high_len  input  CNT_W  gate-high duration in clk cycles. Latched on accepted start.
- low_len  input  CNT_W  gap duration in clk cycles. Latched on accepted start.
- door_out  output  1  registered gate signal.
- busy  output  1  high from cycle after accepted start until return to IDLE.
- done  output  1  one-cycle pulse when a single-shot sequence completes normally.

Behaviour:
- Reset (async, nRST low): state IDLE, door_out=0, busy=0, done=0, counter=0, latched lengths=0. Takes effect immediately, including mid-gate.
- States: IDLE, HIGH, LOW.
- IDLE:
  - start=1, stop=0, high_len!=0 -> latch high_len, low_len, cont; counter=high_len-1; go to HIGH.
  - door_out=1 and busy=1 from the next edge.
  - Latency: start sampled at edge N; door_out high for edges N+1 .. N+high_len, exactly high_len cycles.
  - start with high_len==0 is ignored: stay IDLE, no outputs change.
  - start and stop in the same cycle: stop wins, start ignored.
- HIGH:
  - Counter decrements each cycle.
  - At counter==0: go to LOW, door_out=0, counter=eff_low-1.
  - eff_low = max(low_len, LOW_MIN).
- LOW:
  - Counter decrements each cycle.
  - At counter==0 with cont=1: go to HIGH, reload high_len-1, door_out=1.
  - At counter==0 with cont=0: go to IDLE, busy=0, done=1 for one cycle.
  - Single-shot: done pulses on the edge after the last low cycle; the low gap is always emitted before done.
- stop in HIGH or LOW:
  - Next edge: state IDLE, door_out=0, busy=0, done stays 0.
  - A truncated gate is expected; the counter will report the truncated width.
- start while busy: ignored. Input length changes while busy: no effect until the next accepted start.
- Arithmetic: unsigned CNT_W down-counter, no wrap (reload happens at 0). high_len max 2^CNT_W-1 is legal.
- door_out, busy and done are all registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro GATE_GEN_CNT_EN.
- Defined: adds output port gate_cnt [15:0].
  - Reset 0; cleared on each accepted start.
  - Increments at each HIGH->LOW transition (completed gate). Stop-aborted gates are not counted.
  - Saturates at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package gate_gen_pkg: state enum (IDLE, HIGH, LOW), default CNT_W, LOW_MIN constant, GATE_CNT_W=16.
- Natural sub-module gate_len_cnt: loadable CNT_W down-counter with load, value, en and zero flag. FSM and output registers stay in gate_gen.

Test Plan:
- Reset mid-gate (nRST low while door_out=1, high_len=100) -> door_out, busy, done are 0 immediately; IDLE after release.
- start with high_len=5, low_len=3, cont=0 -> door_out high exactly 5 cycles starting edge N+1, then low 3 cycles; done pulses once at edge N+9; busy=0 from the same edge.
- cont=1, high_len=10, low_len=0 -> repeating 10 high / 2 low (LOW_MIN). stop asserted in 3rd HIGH at count 4 -> door_out 0 next edge; done never pulses. With GATE_GEN_CNT_EN, gate_cnt=2.
- start with high_len=0 -> no state change, busy stays 0. start+stop same cycle with high_len=7 -> ignored.
- Loopback into the frequency counter, high_len=1000, cont=0 -> counter data_out=1000. Changing high_len to 20 while busy has no effect on the current gate.
- start pulsed during HIGH -> ignored; the sequence length is unchanged.

Source files
------------

// File: rtl/gate_gen_pkg.sv
// Shared types and constants for the gate window generator.
// Optional feature macro: GATE_GEN_CNT_EN (completed-gate counter output).
package gate_gen_pkg;

    // Default width of the length registers and the down-counter.
    localparam int DEF_CNT_W = 32;

    // Shortest low gap between gates; the downstream counter needs two
    // cycles to capture and clear between measurement windows.
    localparam int LOW_MIN = 2;

    // Width of the optional completed-gate counter.
    localparam int GATE_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } gate_state_e;

endpackage

// File: rtl/gate_len_cnt.sv
// Loadable down-counter used to time the high and low phases of the gate.
// Load has priority over decrement; decrement stops at zero (no wrap).
module gate_len_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] value_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    // Next value: reload, decrement, or hold.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (en_i && (value_q != '0)) begin
            value_d = value_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign zero_o  = (value_q == '0);

endmodule

// File: rtl/gate_gen.sv
// Gate ("door") window generator: a programmable high pulse followed by a
// programmable low gap, single-shot or continuous.
// Handshake: start is a one-cycle request honoured only in IDLE with
// high_len != 0 and stop low; stop aborts from any state and wins over start.
// All outputs are registered.
// Optional feature macro: GATE_GEN_CNT_EN adds gate_cnt, a saturating count
// of gates that completed their full high phase since the last start.
module gate_gen
    import gate_gen_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LOW_MIN = gate_gen_pkg::LOW_MIN
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    output logic             door_out,
    output logic             busy,
    output logic             done
`ifdef GATE_GEN_CNT_EN
    ,
    output logic [GATE_CNT_W-1:0] gate_cnt
`endif
);

    gate_state_e      state_q, state_d;
    logic             door_q, door_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             cont_q, cont_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;
    logic [CNT_W-1:0] eff_low;

    // Low gap is never shorter than LOW_MIN cycles.
    assign eff_low = (low_q < CNT_W'(LOW_MIN)) ? CNT_W'(LOW_MIN) : low_q;

    gate_len_cnt #(
        .CNT_W (CNT_W)
    ) u_len_cnt (
        .clk        (clk),
        .nRST       (nRST),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .value_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

    // FSM next state, counter control and registered-output next values.
    always_comb begin
        state_d  = state_q;
        door_d   = door_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        high_d   = high_q;
        low_d    = low_q;
        cont_d   = cont_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop && (high_len != '0)) begin
                    high_d   = high_len;
                    low_d    = low_len;
                    cont_d   = cont;
                    cnt_load = 1'b1;
                    cnt_val  = high_len - CNT_W'(1);
                    state_d  = ST_HIGH;
                    door_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_HIGH: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    door_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_zero) begin
                    state_d  = ST_LOW;
                    door_d   = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = eff_low - CNT_W'(1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_LOW: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    door_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_zero) begin
                    if (cont_q) begin
                        state_d  = ST_HIGH;
                        door_d   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = high_q - CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                door_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, output and latched-configuration registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            door_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            high_q  <= '0;
            low_q   <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            door_q  <= door_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            high_q  <= high_d;
            low_q   <= low_d;
            cont_q  <= cont_d;
        end
    end

    assign door_out = door_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef GATE_GEN_CNT_EN
    logic [GATE_CNT_W-1:0] gate_cnt_q;
    logic                  start_acc;
    logic                  gate_cmp;

    assign start_acc = (state_q == ST_IDLE) && (state_d == ST_HIGH);
    assign gate_cmp  = (state_q == ST_HIGH) && (state_d == ST_LOW);

    // Completed-gate counter: cleared on accepted start, saturating.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            gate_cnt_q <= '0;
        end else if (start_acc) begin
            gate_cnt_q <= '0;
        end else if (gate_cmp && (gate_cnt_q != {GATE_CNT_W{1'b1}})) begin
            gate_cnt_q <= gate_cnt_q + GATE_CNT_W'(1);
        end
    end

    assign gate_cnt = gate_cnt_q;
`endif

endmodule

// File: tb/tb_gate_gen.sv
// Self-checking bench for gate_gen. Expected waveform is built as a queue of
// per-cycle output tuples whenever a start is accepted.
module tb_gate_gen;
    import gate_gen_pkg::*;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          nRST;
    logic          start;
    logic          stop;
    logic          cont;
    logic [CW-1:0] high_len;
    logic [CW-1:0] low_len;
    logic          door_out;
    logic          busy;
    logic          done;
`ifdef GATE_GEN_CNT_EN
    logic [GATE_CNT_W-1:0] gate_cnt;
`endif

    gate_gen #(
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .nRST     (nRST),
        .start    (start),
        .stop     (stop),
        .cont     (cont),
        .high_len (high_len),
        .low_len  (low_len),
        .door_out (door_out),
        .busy     (busy),
        .done     (done)
`ifdef GATE_GEN_CNT_EN
        ,
        .gate_cnt (gate_cnt)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Entry bits: {gate_end, done, busy, door}
    logic [3:0] exp_q[$];
    logic [3:0] cur;
    int         m_high;
    int         m_low;
    bit         m_cont;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Append one whole gate: high phase then low gap.
    task automatic push_gate();
        for (int i = 0; i < m_high; i++) exp_q.push_back(4'b0011);
        for (int i = 0; i < m_low; i++) exp_q.push_back((i == 0) ? 4'b1010 : 4'b0010);
    endtask

    task automatic model_pop();
        if (exp_q.size() == 0) begin
            cur = 4'b0000;
        end else begin
            cur = exp_q.pop_front();
            if (cur[3] && m_cnt < 65535) m_cnt++;
            if (exp_q.size() == 0 && m_cont && cur[1]) push_gate();
        end
    endtask

    // Reference model step, applied at each active edge with current inputs.
    task automatic model_update();
        if (stop) begin
            exp_q.delete();
            m_cont = 1'b0;
            cur    = 4'b0000;
        end else if (!cur[1] && start && high_len != '0) begin
            exp_q.delete();
            m_high = int'(high_len);
            m_low  = (int'(low_len) < LOW_MIN) ? LOW_MIN : int'(low_len);
            m_cont = cont;
            m_cnt  = 0;
            push_gate();
            if (!cont) exp_q.push_back(4'b0100);
            model_pop();
        end else begin
            model_pop();
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur    = 4'b0000;
        m_cont = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_door"}, 32'(door_out), 32'(cur[0]));
        check({pfx, "_busy"}, 32'(busy), 32'(cur[1]));
        check({pfx, "_done"}, 32'(done), 32'(cur[2]));
`ifdef GATE_GEN_CNT_EN
        check({pfx, "_gcnt"}, 32'(gate_cnt), 32'(m_cnt));
`endif
    endtask

    // One cycle: model follows the edge, outputs checked on the falling edge.
    task automatic tick(input string pfx);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs(pfx);
    endtask

    task automatic drive(input logic st, input logic sp, input logic ct,
                         input int h, input int l);
        start    = st;
        stop     = sp;
        cont     = ct;
        high_len = CW'(h);
        low_len  = CW'(l);
    endtask

    task automatic idle_run(input string pfx, input int n);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < n; i++) tick(pfx);
    endtask

    int door_cycles;

    initial begin
        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        model_reset();
        #12;
        check("rst_door", 32'(door_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        idle_run("idle", 2);

        // Single shot 5 high / 3 low.
        drive(1'b1, 1'b0, 1'b0, 5, 3);
        tick("ss_start");
        idle_run("ss", 12);

        // Continuous 10 high / LOW_MIN low; stop in the third high at count 4.
        drive(1'b1, 1'b0, 1'b1, 10, 0);
        tick("ct_start");
        idle_run("ct", 29);
        stop = 1'b1;
        tick("ct_stop");
        stop = 1'b0;
`ifdef GATE_GEN_CNT_EN
        check("ct_gcnt_two", 32'(gate_cnt), 32'd2);
`endif
        idle_run("ct_post", 5);

        // Zero-length start, start with stop: both ignored.
        drive(1'b1, 1'b0, 1'b0, 0, 3);
        tick("zero_len");
        drive(1'b1, 1'b1, 1'b0, 7, 3);
        tick("start_stop");
        idle_run("ign", 3);

        // Long single gate; config changes and a second start while busy.
        drive(1'b1, 1'b0, 1'b0, 1000, 4);
        tick("loop_start");
        door_cycles = (door_out === 1'b1) ? 1 : 0;
        drive(1'b0, 1'b0, 1'b1, 20, 0);
        for (int i = 0; i < 1010; i++) begin
            start = (i == 50);
            tick("loop");
            if (door_out === 1'b1) door_cycles++;
        end
        check("loop_width", 32'(door_cycles), 32'd1000);
        idle_run("loop_post", 2);

        // Asynchronous reset in the middle of a gate.
        drive(1'b1, 1'b0, 1'b0, 100, 3);
        tick("mr_start");
        idle_run("mr", 30);
        #2 nRST = 1'b0;
        #1;
        check("mr_door", 32'(door_out), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        model_reset();
        @(negedge clk);
        nRST = 1'b1;
        idle_run("mr_post", 3);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            start    = ($urandom_range(0, 9) < 3);
            stop     = ($urandom_range(0, 39) == 0);
            cont     = $urandom_range(0, 1);
            high_len = CW'($urandom_range(0, 6));
            low_len  = CW'($urandom_range(0, 4));
            tick("rnd");
        end
        idle_run("end", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
